// File: rtl/mat_cache_pkg.sv
// Shared MatCache types: write-op encoding, loader FSM states,
// and the 32-bit IEEE-754 single-precision word carried on the data path.
package mat_cache_pkg;

  // Single-precision value carried as its raw bit pattern.
  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    MAT_CACHE_WRITE_NOP = 2'd0,
    MAT_CACHE_WRITE_ROW = 2'd1,
    MAT_CACHE_WRITE_COL = 2'd2
  } MatCacheWriteOp_t;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_FILL  = 2'd1,
    LDR_WRITE = 2'd2
  } MatCacheLoaderState_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_cache_loader.sv
// Streams scalar elements into a lane buffer and issues one MatCache
// row/column write per WIDTH elements, for cmd_count vectors.
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only when idle)
//   cmd_addr/col/start/count  target matrix, row/col select, first index,
//                           number of vectors (saturates at WIDTH)
//   elem_valid/elem_ready   element handshake (ready only while filling)
//   elem_data               scalar element (fp32 bit pattern)
//   write_op/write_addr1/write_param/wr_data  registered MatCache write
//   done                    one-cycle completion pulse
module mat_cache_loader
  import mat_cache_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4,
  localparam int SW = idx_w(WIDTH),
  localparam int AW = idx_w(CACHE_SIZE)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic             cmd_col,
  input  logic [SW-1:0]    cmd_start,
  input  logic [SW:0]      cmd_count,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  fp32_t            elem_data,
  output MatCacheWriteOp_t write_op,
  output logic [AW-1:0]    write_addr1,
  output logic [SW-1:0]    write_param,
  output fp32_t            wr_data [WIDTH],
  output logic             done
);

  MatCacheLoaderState_t r_state;
  MatCacheLoaderState_t w_next;

  logic [AW-1:0] r_addr;
  logic          r_col;
  logic [SW-1:0] r_start;
  logic [SW-1:0] r_idx;
  logic [SW-1:0] r_lane;
  logic [SW:0]   r_count;
  fp32_t         r_buf [WIDTH];

  fp32_t            w_vec [WIDTH];
  logic             w_cmd_acc;
  logic             w_elem_acc;
  logic             w_lane_last;
  logic             w_vec_last;
  logic [SW:0]      w_count_sat;
  logic [SW:0]      w_sum;
  logic [SW-1:0]    w_param;
  MatCacheWriteOp_t w_op;

  assign cmd_ready  = (r_state == LDR_IDLE);
  assign elem_ready = (r_state == LDR_FILL);
  assign w_cmd_acc  = cmd_valid && cmd_ready;
  assign w_elem_acc = elem_valid && elem_ready;

  assign w_lane_last = (r_lane == SW'(WIDTH - 1));
  assign w_vec_last  = ({1'b0, r_idx} == (r_count - (SW+1)'(1)));

  assign w_count_sat =
    (cmd_count > (SW+1)'(WIDTH)) ? (SW+1)'(WIDTH) : cmd_count;

  // start + idx < 2*WIDTH, so a single conditional subtract is the modulo.
  assign w_sum   = (SW+1)'(r_start) + (SW+1)'(r_idx);
  assign w_param = (w_sum >= (SW+1)'(WIDTH)) ?
                   SW'(w_sum - (SW+1)'(WIDTH)) : SW'(w_sum);

  assign w_op = r_col ? MAT_CACHE_WRITE_COL : MAT_CACHE_WRITE_ROW;

  // Buffer contents including the element arriving this cycle, so the
  // last lane goes straight into the registered write data.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_vec[i] = (r_lane == SW'(i)) ? elem_data : r_buf[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= LDR_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LDR_IDLE: begin
        if (w_cmd_acc && (cmd_count != '0)) w_next = LDR_FILL;
      end
      LDR_FILL: begin
        if (w_elem_acc && w_lane_last) w_next = LDR_WRITE;
      end
      LDR_WRITE: begin
        w_next = w_vec_last ? LDR_IDLE : LDR_FILL;
      end
      default: w_next = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_col       <= 1'b0;
      r_start     <= '0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_count     <= '0;
      write_op    <= MAT_CACHE_WRITE_NOP;
      write_addr1 <= '0;
      write_param <= '0;
      done        <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_buf[i]   <= '0;
        wr_data[i] <= '0;
      end
    end else begin
      done     <= 1'b0;
      write_op <= MAT_CACHE_WRITE_NOP;
      if (w_cmd_acc) begin
        r_addr  <= cmd_addr;
        r_col   <= cmd_col;
        r_start <= cmd_start;
        r_count <= w_count_sat;
        r_idx   <= '0;
        r_lane  <= '0;
        // Empty command completes without visiting FILL.
        if (cmd_count == '0) done <= 1'b1;
      end
      if (w_elem_acc) begin
        r_buf[r_lane] <= elem_data;
        if (w_lane_last) begin
          r_lane      <= '0;
          write_op    <= w_op;
          write_addr1 <= r_addr;
          write_param <= w_param;
          done        <= w_vec_last;
          for (int i = 0; i < WIDTH; i++) begin
            wr_data[i] <= w_vec[i];
          end
        end else begin
          r_lane <= r_lane + SW'(1);
        end
      end
      if ((r_state == LDR_WRITE) && !w_vec_last) begin
        r_idx <= r_idx + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mat_cache_loader.sv
// Randomized self-checking bench for mat_cache_loader against a
// queue-based model of the expected MatCache writes.
module tb_mat_cache_loader;
  import mat_cache_pkg::*;

  localparam int W  = 4;
  localparam int CS = 4;
  localparam int SW = 2;
  localparam int AW = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr = '0;
  logic             cmd_col = 1'b0;
  logic [SW-1:0]    cmd_start = '0;
  logic [SW:0]      cmd_count = '0;
  logic             elem_valid = 1'b0;
  logic             elem_ready;
  fp32_t            elem_data = '0;
  MatCacheWriteOp_t write_op;
  logic [AW-1:0]    write_addr1;
  logic [SW-1:0]    write_param;
  fp32_t            wr_data [W];
  logic             done;

  mat_cache_loader #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_col(cmd_col),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_data(elem_data),
    .write_op(write_op), .write_addr1(write_addr1),
    .write_param(write_param), .wr_data(wr_data),
    .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]      op;
    logic [AW-1:0]   addr;
    logic [SW-1:0]   param;
    logic [W*32-1:0] d;
    logic            last;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   elems[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  bit   zpend = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*32-1:0] pack_wr();
    logic [W*32-1:0] p;
    for (int i = 0; i < W; i++) p[i*32 +: 32] = wr_data[i];
    return p;
  endfunction

  // Small non-negative integer to single-precision bits.
  function automatic logic [31:0] i2f(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (write_op != MAT_CACHE_WRITE_NOP) begin
        if (q.size() == 0) begin
          check("unexp_wr", 128'(write_op), 128'(MAT_CACHE_WRITE_NOP));
        end else begin
          me = q.pop_front();
          check("op", 128'(write_op), 128'(me.op));
          check("addr", 128'(write_addr1), 128'(me.addr));
          check("param", 128'(write_param), 128'(me.param));
          check("data", 128'(pack_wr()), 128'(me.d));
          check("done", 128'(done), 128'(me.last));
          if (done) done_cyc = cyc;
        end
      end else if (done) begin
        check("zdone", 128'(zpend), 128'(1));
        zpend = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  task automatic reset_checks(input string p);
    check({p, "_crdy"}, 128'(cmd_ready), 128'(1));
    check({p, "_erdy"}, 128'(elem_ready), 128'(0));
    check({p, "_op"}, 128'(write_op), 128'(MAT_CACHE_WRITE_NOP));
    check({p, "_addr"}, 128'(write_addr1), 128'(0));
    check({p, "_param"}, 128'(write_param), 128'(0));
    check({p, "_data"}, 128'(pack_wr()), 128'(0));
    check({p, "_done"}, 128'(done), 128'(0));
  endtask

  task automatic fill_rand(input int n);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back(int'($urandom));
  endtask

  task automatic fill_ints(input int n, input int base);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back(int'(i2f(base + i)));
  endtask

  // mode: 0 = elem_valid high, 1 = 1,0,0 pattern, 2 = random stalls.
  // hold: keep cmd_valid asserted through the whole load.
  task automatic run_cmd(input int addr, input int col, input int start,
                         input int cnt, input int mode, input int hold);
    int nv, k, t, accc;
    bit acc;
    exp_t e;
    nv = (cnt > W) ? W : cnt;
    for (int v = 0; v < nv; v++) begin
      e.op    = col ? 2'(MAT_CACHE_WRITE_COL) : 2'(MAT_CACHE_WRITE_ROW);
      e.addr  = AW'(addr);
      e.param = SW'((start + v) % W);
      for (int i = 0; i < W; i++) e.d[i*32 +: 32] = elems[v*W + i];
      e.last  = (v == nv - 1);
      q.push_back(e);
    end
    if (nv == 0) zpend = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_col   = col[0];
    cmd_start = SW'(start);
    cmd_count = (SW+1)'(cnt);
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clock); #1; t++;
    end
    if (!cmd_ready) begin
      check("cmd_to", 128'(cmd_ready), 128'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    accc = cyc;
    if (hold == 0) cmd_valid = 1'b0;
    k = 0;
    t = 0;
    while (k < nv*W && t < 1000) begin
      elem_valid = (mode == 0) ? 1'b1 :
                   (mode == 1) ? (t % 3 == 0) : 1'($urandom);
      elem_data = elems[k];
      if (hold != 0) check("busy", 128'(cmd_ready), 128'(0));
      acc = elem_valid && elem_ready;
      @(posedge clock); #1;
      t++;
      if (acc) k++;
    end
    elem_valid = 1'b0;
    cmd_valid  = 1'b0;
    if (k < nv*W) check("elem_to", 128'(k), 128'(nv*W));
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(posedge clock); #1; t++;
    end
    if (!cmd_ready) check("idle_to", 128'(cmd_ready), 128'(1));
    @(posedge clock); #1;
    if (hold != 0) check("noqueue", 128'(elem_ready), 128'(0));
    check("drain", 128'(q.size()), 128'(0));
    if (nv == 0) check("zpend", 128'(zpend), 128'(0));
    if (mode == 0 && nv > 0)
      check("thru", 128'(done_cyc - accc), 128'(nv*(W+1) - 1));
  endtask

  // Start a 2-vector load, accept nel elements, then reset mid-cycle.
  task automatic part_reset(input int nel, input string p);
    cmd_addr  = AW'(1);
    cmd_col   = 1'b0;
    cmd_start = '0;
    cmd_count = (SW+1)'(2);
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < nel; i++) begin
      elem_valid = 1'b1;
      elem_data  = $urandom;
      @(posedge clock); #1;
    end
    elem_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    reset_checks(p);
    q.delete();
    zpend = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check({p, "_idle"}, 128'(elem_ready), 128'(0));
  endtask

  int t36[16] = '{4, 6, 1, 6, 1, 2, 3, 4, 3, 3, 3, 3, 9, 7, 5, 3};

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset_checks("rst");
    reset_n = 1'b1;
    @(posedge clock); #1;

    elems.delete();
    for (int i = 0; i < 16; i++) elems.push_back(int'(i2f(t36[i])));
    run_cmd(0, 0, 0, 4, 0, 0);

    fill_ints(8, 1);
    run_cmd(2, 1, 3, 2, 0, 0);

    fill_rand(16);
    run_cmd(1, 0, 1, 4, 1, 0);

    run_cmd(3, 0, 0, 0, 0, 0);

    fill_rand(16);
    run_cmd(1, 1, 2, 7, 0, 0);

    fill_rand(8);
    run_cmd(0, 0, 2, 2, 0, 1);

    part_reset(2, "rfill");
    fill_ints(4, 2);
    run_cmd(2, 0, 0, 1, 0, 0);

    part_reset(4, "rwr");
    fill_rand(8);
    run_cmd(3, 1, 1, 2, 0, 0);

    for (int n = 0; n < 20; n++) begin
      fill_rand(16);
      run_cmd(int'($urandom % CS), int'($urandom % 2),
              int'($urandom % W), int'($urandom % 8), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat_cache_loader.md
MAT_CACHE_LOADER -- requirements
Module: mat_cache_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4: vector length, equal to the downstream MatCache WIDTH.
REQ-002 SHALL have parameter CACHE_SIZE, default 4: number of downstream cache matrices.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  load command present.
REQ-007 cmd_ready  out  1  loader idle, command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_addr  in  clog2(CACHE_SIZE)  target cache matrix.
REQ-009 cmd_col  in  1  0 = write rows, 1 = write columns.
REQ-010 cmd_start  in  clog2(WIDTH)  first row/column index.
REQ-011 cmd_count  in  clog2(WIDTH)+1  number of vectors to load.
REQ-012 elem_valid  in  1  scalar element present.
REQ-013 elem_ready  out  1  element accepted when elem_valid && elem_ready.
REQ-014 elem_data  in  shortreal  scalar element.
REQ-015 write_op  out  MatCacheWriteOp_t  to MatCache write_op.
REQ-016 write_addr1  out  clog2(CACHE_SIZE)  to MatCache write_addr1.
REQ-017 write_param  out  clog2(WIDTH)  to MatCache write_param.
REQ-018 wr_data  out  shortreal [WIDTH]  to MatCache data_in.
REQ-019 done  out  1  one-cycle pulse at command completion.

Function
REQ-020 SHALL implement an FSM with states IDLE, FILL and WRITE.
REQ-021 IDLE: cmd_ready=1, elem_ready=0, write_op=MAT_CACHE_WRITE_NOP; on accept, latch cmd fields, vector index=0, lane=0 -> FILL.
REQ-022 cmd_count==0 SHALL go IDLE->IDLE with done=1 the next cycle and no write issued; cmd_count>WIDTH SHALL saturate to WIDTH.
REQ-023 FILL: elem_ready=1, cmd_ready=0; each accepted element SHALL be stored in lane buffer[lane] and lane incremented; lane 0 is filled first.
REQ-024 The WIDTH-th accepted element SHALL move to WRITE; elem_valid low SHALL hold state with no lane change.
REQ-025 WRITE (exactly one cycle): write_op=MAT_CACHE_WRITE_ROW (cmd_col=0) or MAT_CACHE_WRITE_COL (cmd_col=1), write_addr1=latched addr, write_param=(cmd_start+vector index) mod WIDTH, wr_data=lane buffer; elem_ready=0.
REQ-026 From WRITE: if vector index==count-1 -> IDLE with done=1 in the same cycle as that write; else index+1, lane=0 -> FILL.
REQ-027 write_op SHALL be MAT_CACHE_WRITE_NOP in every cycle outside WRITE; wr_data/write_param/write_addr1 hold last values when not writing.
REQ-028 Outputs SHALL be registered: element accepted at edge N (last lane) -> write visible after edge N, captured by MatCache at edge N+1.
REQ-029 Throughput SHALL be WIDTH+1 cycles per vector with elem_valid held high.
REQ-030 cmd_valid during FILL/WRITE SHALL be ignored (cmd_ready=0), not queued.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, cmd_ready=1, elem_ready=0, write_op=MAT_CACHE_WRITE_NOP, write_addr1=0, write_param=0, wr_data all 0.0, done=0, lane=0, vector index=0.
REQ-032 Reset during FILL SHALL discard the partial vector; no write SHALL be issued for it after release.
REQ-033 Reset during WRITE SHALL drop that write from the cycle reset asserts.

Structure
REQ-034 MatCacheWriteOp_t including MAT_CACHE_WRITE_NOP, and the FSM state enum MatCacheLoaderState_t, SHALL live in the shared MatCache package.
REQ-035 Lane buffer and FSM SHALL be in one module; no sub-module.

Verification
REQ-036 Row load: cmd(addr=0,col=0,start=0,count=4), elements 4,6,1,6,1,2,3,4,3,3,3,3,9,7,5,3 -> four ROW writes, params 0..3, done once; MatCache READ_DIAG param 0 returns (4,4,3,7).
REQ-037 Column wrap: cmd(addr=2,col=1,start=3,count=2), elements 1..8 -> COL writes param 3 data (1,2,3,4), then param 0 data (5,6,7,8), done with 2nd write.
REQ-038 Stalls: elem_valid toggling 1,0,0,1,... -> write only after 4th accepted element; data order unchanged.
REQ-039 count=0 -> done pulse one cycle after accept, write_op stays NOP; count=7 -> exactly 4 writes.
REQ-040 Reset after 2 elements of vector 1 -> IDLE, no write; a new cmd then loads correctly from lane 0.
REQ-041 cmd_valid held high during load -> accepted only after done, once.
